// File: rtl/states_pkg.sv
// Shared state encodings for the per-thread pipeline: the core sequencing
// state broadcast to every thread and the load/store unit state reported back.
package states_pkg;

   typedef enum logic [2:0] {
      CORE_IDLE    = 3'd0,
      CORE_FETCH   = 3'd1,
      CORE_DECODE  = 3'd2,
      CORE_REQUEST = 3'd3,
      CORE_WAIT    = 3'd4,
      CORE_EXECUTE = 3'd5,
      CORE_UPDATE  = 3'd6,
      CORE_DONE    = 3'd7
   } core_state_t;

   typedef enum logic [1:0] {
      LSU_IDLE       = 2'd0,
      LSU_REQUESTING = 2'd1,
      LSU_WAITING    = 2'd2,
      LSU_DONE       = 2'd3
   } lsu_state_t;

endpackage

// File: rtl/thread_lsu.sv
// Per-thread load/store unit. Turns an LDR/STR operand pair into one request
// on the read or write channel, waits for the memory controller to accept it,
// and aborts with a sticky error if the request waits too long.
module thread_lsu
   import states_pkg::*;
#(
   parameter int ADDR_BITS      = 8,
   parameter int DATA_BITS      = 8,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   input  logic [2:0]           core_state,
   input  logic                 decoded_mem_read_enable,
   input  logic                 decoded_mem_write_enable,
   input  logic [7:0]           rs,
   input  logic [DATA_BITS-1:0] rt,
   output logic                 mem_read_valid,
   output logic [ADDR_BITS-1:0] mem_read_address,
   input  logic                 mem_read_ready,
   input  logic [DATA_BITS-1:0] mem_read_data,
   output logic                 mem_write_valid,
   output logic [ADDR_BITS-1:0] mem_write_address,
   output logic [DATA_BITS-1:0] mem_write_data,
   input  logic                 mem_write_ready,
   output logic [1:0]           lsu_state,
   output logic [DATA_BITS-1:0] lsu_out,
   output logic                 lsu_error
);

   // Operation latched at request time; local to this unit.
   localparam logic [1:0] OP_NONE  = 2'd0;
   localparam logic [1:0] OP_READ  = 2'd1;
   localparam logic [1:0] OP_WRITE = 2'd2;

   // Last timer value before the watchdog aborts; the timer never exceeds it.
   localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT_CYCLES - 1);

   lsu_state_t state;
   logic [1:0] op;
   logic [1:0] op_sel;
   logic [7:0] timer;
   logic       ready_seen;

   // Pick the operation (read has priority) and the ready of the channel in use.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      op_sel = OP_NONE;
      if (decoded_mem_read_enable)
         op_sel = OP_READ;
      else if (decoded_mem_write_enable)
         op_sel = OP_WRITE;
      ready_seen = (op == OP_READ) ? mem_read_ready : mem_write_ready;
   end

   // Request sequencing, watchdog and result capture; frozen while enable is low.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state             <= LSU_IDLE;
         op                <= OP_NONE;
         timer             <= '0;
         mem_read_valid    <= 1'b0;
         mem_read_address  <= '0;
         mem_write_valid   <= 1'b0;
         mem_write_address <= '0;
         mem_write_data    <= '0;
         lsu_out           <= '0;
         lsu_error         <= 1'b0;
      end else if (enable) begin
         case (state)
            LSU_IDLE: begin
               if (core_state == CORE_REQUEST && op_sel != OP_NONE) begin
                  op        <= op_sel;
                  lsu_error <= 1'b0;
                  state     <= LSU_REQUESTING;
               end
            end
            LSU_REQUESTING: begin
               if (op == OP_READ) begin
                  mem_read_valid   <= 1'b1;
                  mem_read_address <= rs[ADDR_BITS-1:0];
               end else begin
                  mem_write_valid   <= 1'b1;
                  mem_write_address <= rs[ADDR_BITS-1:0];
                  mem_write_data    <= rt;
               end
               timer <= '0;
               state <= LSU_WAITING;
            end
            LSU_WAITING: begin
               // Ready is checked first so an acceptance on the abort edge still succeeds.
               if (ready_seen) begin
                  mem_read_valid  <= 1'b0;
                  mem_write_valid <= 1'b0;
                  if (op == OP_READ)
                     lsu_out <= mem_read_data;
                  state <= LSU_DONE;
               end else if (timer == TIMER_LAST) begin
                  mem_read_valid  <= 1'b0;
                  mem_write_valid <= 1'b0;
                  lsu_error       <= 1'b1;
                  if (op == OP_READ)
                     lsu_out <= '0;
                  state <= LSU_DONE;
               end else begin
                  timer <= timer + 8'd1;
               end
            end
            LSU_DONE: begin
               // lsu_out holds through UPDATE so the register file can capture it.
               if (core_state == CORE_UPDATE)
                  state <= LSU_IDLE;
            end
            default: state <= LSU_IDLE;
         endcase
      end
   end

   assign lsu_state = state;

endmodule

// File: tb/tb_thread_lsu.sv
// Directed bench for thread_lsu with a short watchdog so timeout and the
// ready-on-abort-edge boundary are reachable in a few cycles.
module tb_thread_lsu;
   import states_pkg::*;

   logic       clk;
   logic       reset;
   logic       enable;
   logic [2:0] core_state;
   logic       rd_en;
   logic       wr_en;
   logic [7:0] rs;
   logic [7:0] rt;
   logic       mem_read_valid;
   logic [7:0] mem_read_address;
   logic       mem_read_ready;
   logic [7:0] mem_read_data;
   logic       mem_write_valid;
   logic [7:0] mem_write_address;
   logic [7:0] mem_write_data;
   logic       mem_write_ready;
   logic [1:0] lsu_state;
   logic [7:0] lsu_out;
   logic       lsu_error;

   int tests_run = 0;
   int tests_failed = 0;

   thread_lsu #(
      .ADDR_BITS(8),
      .DATA_BITS(8),
      .TIMEOUT_CYCLES(4)
   ) dut (
      .clk                      (clk),
      .reset                    (reset),
      .enable                   (enable),
      .core_state               (core_state),
      .decoded_mem_read_enable  (rd_en),
      .decoded_mem_write_enable (wr_en),
      .rs                       (rs),
      .rt                       (rt),
      .mem_read_valid           (mem_read_valid),
      .mem_read_address         (mem_read_address),
      .mem_read_ready           (mem_read_ready),
      .mem_read_data            (mem_read_data),
      .mem_write_valid          (mem_write_valid),
      .mem_write_address        (mem_write_address),
      .mem_write_data           (mem_write_data),
      .mem_write_ready          (mem_write_ready),
      .lsu_state                (lsu_state),
      .lsu_out                  (lsu_out),
      .lsu_error                (lsu_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0] cs;
      logic       rd;
      logic       wr;
      logic [7:0] rs;
      logic [7:0] rt;
      logic       rrdy;
      logic [7:0] rdata;
      logic       wrdy;
      logic [1:0] e_st;
      logic       e_rv;
      logic       e_wv;
      logic [7:0] e_addr;
      logic [7:0] e_wdata;
      logic [7:0] e_out;
      logic       e_err;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Advance one rising edge and settle just after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [2:0] cs, input logic rd, input logic wr,
                        input logic [7:0] a, input logic [7:0] d,
                        input logic rr, input logic [7:0] rdat, input logic wrr);
      core_state      = cs;
      rd_en           = rd;
      wr_en           = wr;
      rs              = a;
      rt              = d;
      mem_read_ready  = rr;
      mem_read_data   = rdat;
      mem_write_ready = wrr;
   endtask

   // Issue a load from IDLE and bring it into WAITING with valid raised.
   task automatic start_load(input logic [7:0] a);
      drive(3'(CORE_REQUEST), 1'b1, 1'b0, a, 8'h00, 1'b0, 8'h00, 1'b0);
      step();
      drive(3'(CORE_WAIT), 1'b1, 1'b0, a, 8'h00, 1'b0, 8'h00, 1'b0);
      step();
   endtask

   task automatic finish_update();
      drive(3'(CORE_UPDATE), 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
      step();
      check("update_to_idle", 32'(lsu_state), 32'd0);
   endtask

   initial begin
      int cnt;
      reset  = 1'b1;
      enable = 1'b1;
      drive(3'(CORE_IDLE), 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
      #12;
      check("reset_state", 32'(lsu_state), 32'd0);
      check("reset_rvalid", 32'(mem_read_valid), 32'd0);
      check("reset_wvalid", 32'(mem_write_valid), 32'd0);
      check("reset_out", 32'(lsu_out), 32'd0);
      check("reset_err", 32'(lsu_error), 32'd0);
      @(negedge clk);
      reset = 1'b0;

      // cs rd wr rs rt rrdy rdata wrdy | st rv wv addr wdata out err
      // Basic load: ready on the 3rd valid cycle with 0xA5.
      vecs.push_back('{3'd3,1,0,8'h3C,8'h00,0,8'h00,0, 2'd1,0,0,8'h00,8'h00,8'h00,0});
      vecs.push_back('{3'd4,1,0,8'h3C,8'h00,0,8'h00,0, 2'd2,1,0,8'h3C,8'h00,8'h00,0});
      vecs.push_back('{3'd4,1,0,8'h3C,8'h00,0,8'h00,0, 2'd2,1,0,8'h3C,8'h00,8'h00,0});
      vecs.push_back('{3'd4,1,0,8'h3C,8'h00,0,8'h00,0, 2'd2,1,0,8'h3C,8'h00,8'h00,0});
      vecs.push_back('{3'd4,1,0,8'h3C,8'h00,1,8'hA5,0, 2'd3,0,0,8'h00,8'h00,8'hA5,0});
      vecs.push_back('{3'd5,0,0,8'h00,8'h00,0,8'h00,0, 2'd3,0,0,8'h00,8'h00,8'hA5,0});
      vecs.push_back('{3'd6,0,0,8'h00,8'h00,0,8'h00,0, 2'd0,0,0,8'h00,8'h00,8'hA5,0});
      // Basic store: ready on first valid cycle; read ready on idle channel ignored.
      vecs.push_back('{3'd3,0,1,8'h10,8'h7E,0,8'h00,0, 2'd1,0,0,8'h00,8'h00,8'hA5,0});
      vecs.push_back('{3'd4,0,1,8'h10,8'h7E,0,8'h00,0, 2'd2,0,1,8'h10,8'h7E,8'hA5,0});
      vecs.push_back('{3'd4,0,1,8'h10,8'h7E,1,8'hFF,1, 2'd3,0,0,8'h00,8'h00,8'hA5,0});
      vecs.push_back('{3'd6,0,0,8'h00,8'h00,0,8'h00,0, 2'd0,0,0,8'h00,8'h00,8'hA5,0});
      // Both enables: read channel only.
      vecs.push_back('{3'd3,1,1,8'h55,8'h33,0,8'h00,0, 2'd1,0,0,8'h00,8'h00,8'hA5,0});
      vecs.push_back('{3'd4,1,1,8'h55,8'h33,0,8'h00,0, 2'd2,1,0,8'h55,8'h00,8'hA5,0});
      vecs.push_back('{3'd4,1,1,8'h55,8'h33,1,8'h12,1, 2'd3,0,0,8'h00,8'h00,8'h12,0});
      vecs.push_back('{3'd6,0,0,8'h00,8'h00,0,8'h00,0, 2'd0,0,0,8'h00,8'h00,8'h12,0});
      // REQUEST with no op, and ready outside WAITING: nothing happens.
      vecs.push_back('{3'd3,0,0,8'h44,8'h00,1,8'h99,1, 2'd0,0,0,8'h00,8'h00,8'h12,0});
      vecs.push_back('{3'd4,0,0,8'h44,8'h00,1,8'h99,1, 2'd0,0,0,8'h00,8'h00,8'h12,0});

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].cs, vecs[i].rd, vecs[i].wr, vecs[i].rs, vecs[i].rt,
               vecs[i].rrdy, vecs[i].rdata, vecs[i].wrdy);
         step();
         check($sformatf("v%0d_state", i), 32'(lsu_state), 32'(vecs[i].e_st));
         check($sformatf("v%0d_rvalid", i), 32'(mem_read_valid), 32'(vecs[i].e_rv));
         check($sformatf("v%0d_wvalid", i), 32'(mem_write_valid), 32'(vecs[i].e_wv));
         check($sformatf("v%0d_out", i), 32'(lsu_out), 32'(vecs[i].e_out));
         check($sformatf("v%0d_err", i), 32'(lsu_error), 32'(vecs[i].e_err));
         if (vecs[i].e_rv)
            check($sformatf("v%0d_raddr", i), 32'(mem_read_address), 32'(vecs[i].e_addr));
         if (vecs[i].e_wv) begin
            check($sformatf("v%0d_waddr", i), 32'(mem_write_address), 32'(vecs[i].e_addr));
            check($sformatf("v%0d_wdata", i), 32'(mem_write_data), 32'(vecs[i].e_wdata));
         end
      end

      // Timeout: ready never comes; valid must last exactly 4 cycles.
      start_load(8'h20);
      cnt = mem_read_valid ? 1 : 0;
      for (int k = 0; k < 20; k++) begin
         if (!mem_read_valid) break;
         step();
         if (mem_read_valid) cnt++;
      end
      check("timeout_valid_cycles", 32'(cnt), 32'd4);
      check("timeout_state", 32'(lsu_state), 32'd3);
      check("timeout_err", 32'(lsu_error), 32'd1);
      check("timeout_out", 32'(lsu_out), 32'd0);
      finish_update();
      check("err_sticky_idle", 32'(lsu_error), 32'd1);

      // Follow-up load clears the error and completes.
      drive(3'(CORE_REQUEST), 1'b1, 1'b0, 8'h21, 8'h00, 1'b0, 8'h00, 1'b0);
      step();
      check("err_cleared", 32'(lsu_error), 32'd0);
      drive(3'(CORE_WAIT), 1'b1, 1'b0, 8'h21, 8'h00, 1'b0, 8'h00, 1'b0);
      step();
      drive(3'(CORE_WAIT), 1'b1, 1'b0, 8'h21, 8'h00, 1'b1, 8'h66, 1'b0);
      step();
      check("followup_state", 32'(lsu_state), 32'd3);
      check("followup_out", 32'(lsu_out), 32'h66);
      check("followup_err", 32'(lsu_error), 32'd0);
      finish_update();

      // Boundary: ready on the 4th valid cycle wins over the abort.
      start_load(8'h30);
      for (int k = 0; k < 3; k++) begin
         drive(3'(CORE_WAIT), 1'b1, 1'b0, 8'h30, 8'h00, 1'b0, 8'h00, 1'b0);
         step();
      end
      check("boundary_still_valid", 32'(mem_read_valid), 32'd1);
      drive(3'(CORE_WAIT), 1'b1, 1'b0, 8'h30, 8'h00, 1'b1, 8'hC3, 1'b0);
      step();
      check("boundary_state", 32'(lsu_state), 32'd3);
      check("boundary_err", 32'(lsu_error), 32'd0);
      check("boundary_out", 32'(lsu_out), 32'hC3);
      finish_update();

      // Freeze mid-WAITING with ready high: nothing moves until re-enabled.
      start_load(8'h40);
      enable = 1'b0;
      drive(3'(CORE_WAIT), 1'b1, 1'b0, 8'h40, 8'h00, 1'b1, 8'h77, 1'b0);
      step();
      step();
      check("freeze_state", 32'(lsu_state), 32'd2);
      check("freeze_valid", 32'(mem_read_valid), 32'd1);
      check("freeze_out", 32'(lsu_out), 32'hC3);
      enable = 1'b1;
      step();
      check("thaw_state", 32'(lsu_state), 32'd3);
      check("thaw_valid", 32'(mem_read_valid), 32'd0);
      check("thaw_out", 32'(lsu_out), 32'h77);
      finish_update();

      // Asynchronous reset between edges while a request is in flight.
      start_load(8'h50);
      check("pre_reset_valid", 32'(mem_read_valid), 32'd1);
      #2;
      reset = 1'b1;
      #1;
      check("async_reset_valid", 32'(mem_read_valid), 32'd0);
      check("async_reset_state", 32'(lsu_state), 32'd0);
      check("async_reset_out", 32'(lsu_out), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      drive(3'(CORE_IDLE), 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
      step();
      check("post_reset_idle", 32'(lsu_state), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
